freq_generator: RTL and testbench

- Programmable square-wave generator; the transmit-side counterpart of the team's frequency counter.
- Synthesises clk_out at an integer frequency in Hz, derived from the reference clock clk, using a phase accumulator.
- Over any REF_FREQ-cycle window, clk_out contains exactly freq rising edges. A frequency counter on the same reference therefore reads back the programmed value.
- Used to produce test and stimulus clocks and to self-check the frequency-measurement path.

---
 rtl/freq_generator.sv | 149 ++++++++++++++
 tb/tb_freq_generator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_generator.sv
// Phase-accumulator square-wave generator: clk_out carries exactly freq rising edges per REF_FREQ clk cycles.
// Optional FREQ_GEN_BURST_EN adds burst_len/done for edge-triggered bursts of a fixed number of pulses.
module freq_generator #(
    parameter int REF_FREQ = 100000000,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] freq_in,
    input  logic             freq_valid,
    output logic             freq_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             err
`ifdef FREQ_GEN_BURST_EN
    ,
    input  logic [15:0]      burst_len,
    output logic             done
`endif
);

    localparam int SZ_ACC = $clog2(2*REF_FREQ+1);
    localparam logic [SZ_ACC-1:0] REF_C = SZ_ACC'(REF_FREQ);
    localparam logic [WIDTH-1:0]  MAX_F = WIDTH'(REF_FREQ/2);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state, state_nxt;
    logic [SZ_ACC-1:0] acc, acc_nxt, inc, sum;
    logic              clk_out_nxt, tick_nxt, wrap, accept, en_eff;

    assign accept = freq_valid & freq_ready;
    // acc < REF_FREQ and 2*inc <= REF_FREQ, so the sum always fits in SZ_ACC bits
    assign sum    = acc + (inc << 1);
    assign wrap   = (sum >= REF_C);

`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_len_q, burst_cnt;
    logic        hold, burst_hit;

    // hold blocks restarts after a completed burst until en has been seen low
    assign en_eff = en & ~hold;
`else
    assign en_eff = en;
`endif

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        clk_out_nxt = clk_out;
        tick_nxt    = 1'b0;
`ifdef FREQ_GEN_BURST_EN
        burst_hit   = 1'b0;
`endif
        if (state == RUN || state == STOP) begin
            acc_nxt = wrap ? (sum - REF_C) : sum;
            if (wrap) begin
                clk_out_nxt = ~clk_out;
                tick_nxt    = ~clk_out;
            end
        end
        case (state)
            IDLE: begin
                clk_out_nxt = 1'b0;
                if (en_eff) begin
                    state_nxt = RUN;
                    acc_nxt   = '0;
                end
            end
            RUN: begin
                if (!en_eff) state_nxt = STOP;
            end
            STOP: begin
                if (en_eff) begin
                    state_nxt = RUN;
                end else if (!clk_out) begin
                    // a rising toggle here would start a pulse that is cut at once
                    state_nxt   = IDLE;
                    clk_out_nxt = 1'b0;
                    tick_nxt    = 1'b0;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end else if (inc == '0) begin
                    clk_out_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                clk_out_nxt = 1'b0;
            end
        endcase
`ifdef FREQ_GEN_BURST_EN
        burst_hit = (burst_len_q != 16'd0) && tick_nxt && (burst_cnt + 16'd1 == burst_len_q);
        if (burst_hit && state_nxt == RUN) state_nxt = STOP;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            inc        <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
            err        <= 1'b0;
            freq_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            clk_out    <= clk_out_nxt;
            tick       <= tick_nxt;
            running    <= (state_nxt != IDLE);
            freq_ready <= (state_nxt != STOP);
            if (accept) begin
                if (freq_in <= MAX_F) begin
                    inc <= SZ_ACC'(freq_in);
                    err <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef FREQ_GEN_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_len_q <= '0;
            burst_cnt   <= '0;
            hold        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == RUN) begin
                burst_len_q <= burst_len;
                burst_cnt   <= '0;
            end else if (tick_nxt) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            hold <= (hold | burst_hit) & en;
            done <= (state == STOP) && (state_nxt == IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator: edge-count windows, closed-form phase model, stop/restart corners, loopback.
module tb_freq_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, freq_valid, freq_ready, clk_out, tick, running, err;
    logic [31:0] freq_in;
    logic        en2, freq_valid2, freq_ready2, clk_out2, tick2, running2, err2;
    logic [31:0] freq_in2;
`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_len, burst_len2;
    logic        done, done2;
`endif

    always #5 clk = ~clk;

    freq_generator #(.REF_FREQ(100), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .freq_in(freq_in), .freq_valid(freq_valid),
        .freq_ready(freq_ready), .clk_out(clk_out), .tick(tick), .running(running), .err(err)
`ifdef FREQ_GEN_BURST_EN
        , .burst_len(burst_len), .done(done)
`endif
    );

    freq_generator #(.REF_FREQ(1000), .WIDTH(32)) dut_lb (
        .clk(clk), .rst(rst), .en(en2), .freq_in(freq_in2), .freq_valid(freq_valid2),
        .freq_ready(freq_ready2), .clk_out(clk_out2), .tick(tick2), .running(running2), .err(err2)
`ifdef FREQ_GEN_BURST_EN
        , .burst_len(burst_len2), .done(done2)
`endif
    );

    typedef struct {
        int f;
        int e_err;
        int e_ticks;
    } vec_t;

    vec_t tbl [7];
    int   checks = 0;
    int   errors = 0;
    int   f, cnt, dcnt, tnow, tprev;
    logic prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int fv);
        freq_in    = fv;
        freq_valid = 1'b1;
        step();
        freq_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (running && k < 400) begin
            step();
            k++;
        end
        check(name, running, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{25, 0, 25};
        tbl[1] = '{30, 0, 30};
        tbl[2] = '{50, 0, 50};
        tbl[3] = '{51, 1, 50};
        tbl[4] = '{10, 0, 10};
        tbl[5] = '{0,  0, 0};
        tbl[6] = '{1,  0, 1};

        rst = 1'b1;
        en = 1'b0; freq_valid = 1'b0; freq_in = '0;
        en2 = 1'b0; freq_valid2 = 1'b0; freq_in2 = '0;
`ifdef FREQ_GEN_BURST_EN
        burst_len = '0; burst_len2 = '0;
`endif
        #23;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_running", running, 0);
        check("rst_err", err, 0);
        check("rst_ready", freq_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        step();
        check("ready_after_rst", freq_ready, 1);

        // first tick latency and clean stop from the high phase
        offer(25);
        check("err_25", err, 0);
        en = 1'b1;
        step();
        check("entry_running", running, 1);
        check("entry_clk", clk_out, 0);
        step();
        check("n1_clk", clk_out, 0);
        step();
        check("first_tick_clk", clk_out, 1);
        check("first_tick", tick, 1);
        en = 1'b0;
        step();
        check("stop_high_held", clk_out, 1);
        check("stop_running", running, 1);
        check("stop_ready", freq_ready, 0);
        step();
        check("stop_idle", running, 0);
        check("stop_clk_low", clk_out, 0);

        // table of rates applied while running, tick count per 100-cycle window
        en = 1'b1;
        step();
        foreach (tbl[i]) begin
            offer(tbl[i].f);
            check($sformatf("err_f%0d", tbl[i].f), err, tbl[i].e_err);
            step(); step();
            cnt = 0;
            for (int c = 0; c < 100; c++) begin
                step();
                cnt += int'(tick);
            end
            check($sformatf("ticks_f%0d", tbl[i].f), cnt, tbl[i].e_ticks);
        end
        en = 1'b0;
        wait_idle("table_stop");
        check("table_stop_clk", clk_out, 0);

        // brief en drop in the high phase must not disturb the waveform
        offer(10);
        en = 1'b1;
        step();
        for (int n = 1; n <= 30; n++) begin
            step();
            check($sformatf("restart_clk_n%0d", n), clk_out, ((n * 20) / 100) % 2);
            check($sformatf("restart_run_n%0d", n), running, 1);
            if (n == 6) en = 1'b0;
            if (n == 7) en = 1'b1;
        end
        en = 1'b0;
        wait_idle("restart_stop");

        // inc=0 freezes the high level; stopping then forces it low
        offer(25);
        en = 1'b1;
        step(); step(); step();
        check("freeze_start_high", clk_out, 1);
        offer(0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("freeze_hold", clk_out, 1);
        end
        en = 1'b0;
        step();
        check("zero_stop_run", running, 1);
        step();
        check("zero_idle", running, 0);
        check("zero_idle_clk", clk_out, 0);

        // random rates, started with accept and en in the same cycle, against closed-form phase
        for (int k = 0; k < 10; k++) begin
            f = $urandom_range(0, 50);
            freq_in = f; freq_valid = 1'b1; en = 1'b1;
            step();
            freq_valid = 1'b0;
            check("rnd_entry_run", running, 1);
            check("rnd_entry_clk", clk_out, 0);
            for (int n = 1; n <= 50; n++) begin
                step();
                tnow  = (n * 2 * f) / 100;
                tprev = ((n - 1) * 2 * f) / 100;
                check($sformatf("rnd_clk_f%0d_n%0d", f, n), clk_out, tnow % 2);
                check($sformatf("rnd_tick_f%0d_n%0d", f, n), tick, (tnow != tprev) && (tnow % 2 == 1));
            end
            en = 1'b0;
            wait_idle("rnd_stop");
            check("rnd_idle_clk", clk_out, 0);
            check("rnd_err", err, 0);
        end

        // loopback at REF_FREQ=1000: rising edges per 1000-cycle window
        freq_in2 = 123; freq_valid2 = 1'b1; en2 = 1'b1;
        step();
        freq_valid2 = 1'b0;
        prev = clk_out2;
        for (int w = 0; w < 3; w++) begin
            cnt = 0;
            for (int c = 0; c < 1000; c++) begin
                step();
                if (clk_out2 && !prev) cnt++;
                prev = clk_out2;
            end
            if (w > 0) check($sformatf("loopback_w%0d", w), cnt, 123);
        end
        en2 = 1'b0;

`ifdef FREQ_GEN_BURST_EN
        offer(25);
        burst_len = 16'd5;
        en = 1'b1;
        cnt = 0; dcnt = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            cnt  += int'(tick);
            dcnt += int'(done);
        end
        check("burst_ticks", cnt, 5);
        check("burst_done", dcnt, 1);
        check("burst_idle", running, 0);
        en = 1'b0;
        step();
        burst_len = 16'd0;
`endif

        // asynchronous reset in the high phase
        offer(25);
        en = 1'b1;
        step(); step(); step();
        check("prerst_high", clk_out, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_clk", clk_out, 0);
        check("async_rst_run", running, 0);
        check("async_rst_ready", freq_ready, 0);
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", freq_ready, 1);
        check("post_rst_clk", clk_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
